// File: rtl/svc_rv_pkg.sv
// Shared RV definitions: memory-arbiter grant encoding and bus widths.
package svc_rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    // Owner of the SRAM cycle; registered, it names who receives the next response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IRD  = 2'd1,
        DRD  = 2'd2,
        DWR  = 2'd3
    } mem_grant_e;

endpackage

// File: rtl/svc_rv_mem_rsp_hold.sv
// One-entry read response stage: bypasses fresh SRAM data and holds it while the consumer stalls.
module svc_rv_mem_rsp_hold
    import svc_rv_pkg::*;
#(
    parameter int unsigned W = XLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         hold_valid;
    logic [W-1:0] hold_data;

    // The arbiter only issues a read when this slot frees, so in_valid and hold_valid never overlap.
    assign out_valid = in_valid | hold_valid;
    assign out_data  = in_valid ? in_data : hold_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else begin
            hold_valid <= out_valid && !out_ready;
            if (in_valid) begin
                hold_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/svc_rv_mem_arbiter.sv
// Arbitrates instruction reads, data reads and data writes onto one single-port SRAM,
// with write priority and a starvation escape for instruction fetch.
module svc_rv_mem_arbiter
    import svc_rv_pkg::*;
#(
    parameter int unsigned AW         = 10,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [XLEN-1:0]   imem_araddr,
    input  logic              imem_arvalid,
    output logic              imem_arready,
    output logic [XLEN-1:0]   imem_rdata,
    output logic              imem_rvalid,
    input  logic              imem_rready,

    input  logic [XLEN-1:0]   dmem_araddr,
    input  logic              dmem_arvalid,
    output logic              dmem_arready,
    output logic [XLEN-1:0]   dmem_rdata,
    output logic              dmem_rvalid,
    input  logic              dmem_rready,

    input  logic [XLEN-1:0]   dmem_awaddr,
    input  logic              dmem_awvalid,
    output logic              dmem_awready,
    input  logic [XLEN-1:0]   dmem_wdata,
    input  logic [STRB_W-1:0] dmem_wstrb,
    input  logic              dmem_wvalid,
    output logic              dmem_wready,

    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int unsigned SW = $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

    mem_grant_e    state_q, state_d;
    logic [SW-1:0] starve_q;

    logic write_req;
    logic imem_elig;
    logic dmem_elig;

    assign write_req = dmem_awvalid && dmem_wvalid;
    assign imem_elig = imem_arvalid && (!imem_rvalid || imem_rready);
    assign dmem_elig = dmem_arvalid && (!dmem_rvalid || dmem_rready);

    assign mem_wdata = dmem_wdata;

    // Next grant and the combinational handshake/SRAM outputs that follow from it.
    always_comb begin
        state_d      = IDLE;
        imem_arready = 1'b0;
        dmem_arready = 1'b0;
        dmem_awready = 1'b0;
        dmem_wready  = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = imem_araddr[AW+1:2];
        mem_wstrb    = '0;

        if (rst_n) begin
            if (imem_elig && starve_q == STARVE_MAX) begin
                state_d = IRD;
            end else if (write_req) begin
                state_d = DWR;
            end else if (dmem_elig) begin
                state_d = DRD;
            end else if (imem_elig) begin
                state_d = IRD;
            end
        end

        unique case (state_d)
            IRD: begin
                imem_arready = 1'b1;
                mem_en       = 1'b1;
            end
            DRD: begin
                dmem_arready = 1'b1;
                mem_en       = 1'b1;
                mem_addr     = dmem_araddr[AW+1:2];
            end
            DWR: begin
                dmem_awready = 1'b1;
                dmem_wready  = 1'b1;
                mem_en       = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = dmem_awaddr[AW+1:2];
                mem_wstrb    = dmem_wstrb;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q <= state_d;
            if (!imem_arvalid || state_d == IRD) begin
                starve_q <= '0;
            end else if (starve_q != STARVE_MAX) begin
                starve_q <= starve_q + SW'(1);
            end
        end
    end

    svc_rv_mem_rsp_hold #(.W(XLEN)) u_imem_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (state_q == IRD),
        .in_data   (mem_rdata),
        .out_valid (imem_rvalid),
        .out_data  (imem_rdata),
        .out_ready (imem_rready)
    );

    svc_rv_mem_rsp_hold #(.W(XLEN)) u_dmem_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (state_q == DRD),
        .in_data   (mem_rdata),
        .out_valid (dmem_rvalid),
        .out_data  (dmem_rdata),
        .out_ready (dmem_rready)
    );

    // Address bits outside the SRAM window alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_araddr[XLEN-1:AW+2], imem_araddr[1:0],
                                dmem_araddr[XLEN-1:AW+2], dmem_araddr[1:0],
                                dmem_awaddr[XLEN-1:AW+2], dmem_awaddr[1:0]};

endmodule

// File: tb/tb_svc_rv_mem_arbiter.sv
// Self-checking bench for svc_rv_mem_arbiter: grant-priority vector table, directed
// corner sequences, and a read-response scoreboard against a reference memory model.
module tb_svc_rv_mem_arbiter;

    localparam int AW = 10;
    localparam int MAX_STARVE = 4;
    localparam int DEPTH = 1 << AW;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_araddr;
    logic        imem_arvalid;
    logic        imem_arready;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        imem_rready;
    logic [31:0] dmem_araddr;
    logic        dmem_arvalid;
    logic        dmem_arready;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic        dmem_rready;
    logic [31:0] dmem_awaddr;
    logic        dmem_awvalid;
    logic        dmem_awready;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_wvalid;
    logic        dmem_wready;
    logic        mem_en;
    logic        mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    logic [31:0] sram    [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] iq[$];
    logic [31:0] dq[$];

    svc_rv_mem_arbiter #(.AW(AW), .MAX_STARVE(MAX_STARVE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_araddr  (imem_araddr),
        .imem_arvalid (imem_arvalid),
        .imem_arready (imem_arready),
        .imem_rdata   (imem_rdata),
        .imem_rvalid  (imem_rvalid),
        .imem_rready  (imem_rready),
        .dmem_araddr  (dmem_araddr),
        .dmem_arvalid (dmem_arvalid),
        .dmem_arready (dmem_arready),
        .dmem_rdata   (dmem_rdata),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rready  (dmem_rready),
        .dmem_awaddr  (dmem_awaddr),
        .dmem_awvalid (dmem_awvalid),
        .dmem_awready (dmem_awready),
        .dmem_wdata   (dmem_wdata),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_wvalid  (dmem_wvalid),
        .dmem_wready  (dmem_wready),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM with byte strobes and a one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    typedef struct {
        string name;
        logic iv, dv, awv, wv;
        logic exp_i, exp_d, exp_w, exp_en, exp_we;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[12];

    task automatic applyStimulus(input vec_t v, input int idx);
        imem_araddr  = 32'h8000_0040;
        dmem_araddr  = 32'hFFFF_F084;
        dmem_awaddr  = 32'h0000_0088;
        dmem_wdata   = 32'h1000_0000 + idx;
        dmem_wstrb   = 4'b0101;
        imem_arvalid = v.iv;
        dmem_arvalid = v.dv;
        dmem_awvalid = v.awv;
        dmem_wvalid  = v.wv;
    endtask

    task automatic idleInputs();
        imem_arvalid = 1'b0;
        dmem_arvalid = 1'b0;
        dmem_awvalid = 1'b0;
        dmem_wvalid  = 1'b0;
    endtask

    // Scoreboard monitor: samples mid low-phase, well clear of the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                iq.delete();
                dq.delete();
            end else begin
                if (imem_rvalid && imem_rready) begin
                    if (iq.size() == 0) checkOutput("imem_spurious_rvalid", {31'd0, imem_rvalid}, 32'd0);
                    else checkOutput("imem_rsp_data", imem_rdata, iq.pop_front());
                end
                if (dmem_rvalid && dmem_rready) begin
                    if (dq.size() == 0) checkOutput("dmem_spurious_rvalid", {31'd0, dmem_rvalid}, 32'd0);
                    else checkOutput("dmem_rsp_data", dmem_rdata, dq.pop_front());
                end
                if (dmem_awvalid && dmem_wvalid && dmem_awready && dmem_wready) begin
                    for (int b = 0; b < 4; b++) begin
                        if (dmem_wstrb[b]) ref_mem[dmem_awaddr[AW+1:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
                    end
                end
                if (imem_arvalid && imem_arready) iq.push_back(ref_mem[imem_araddr[AW+1:2]]);
                if (dmem_arvalid && dmem_arready) dq.push_back(ref_mem[dmem_araddr[AW+1:2]]);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cnt;
        logic got;

        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 + i;
        end
        sram[4]     = 32'hDEAD_BEEF;  ref_mem[4]  = 32'hDEAD_BEEF;
        sram[12]    = 32'hCAFE_F00D;  ref_mem[12] = 32'hCAFE_F00D;
        mem_rdata   = 32'h0;

        vecs[0]  = '{"none",      0,0,0,0, 0,0,0,0,0, 32'd0};
        vecs[1]  = '{"i_only",    1,0,0,0, 1,0,0,1,0, 32'd16};
        vecs[2]  = '{"d_only",    0,1,0,0, 0,1,0,1,0, 32'd33};
        vecs[3]  = '{"aw_only",   0,0,1,0, 0,0,0,0,0, 32'd0};
        vecs[4]  = '{"w_only",    0,0,0,1, 0,0,0,0,0, 32'd0};
        vecs[5]  = '{"write",     0,0,1,1, 0,0,1,1,1, 32'd34};
        vecs[6]  = '{"i_d",       1,1,0,0, 0,1,0,1,0, 32'd33};
        vecs[7]  = '{"i_wr",      1,0,1,1, 0,0,1,1,1, 32'd34};
        vecs[8]  = '{"d_wr",      0,1,1,1, 0,0,1,1,1, 32'd34};
        vecs[9]  = '{"all",       1,1,1,1, 0,0,1,1,1, 32'd34};
        vecs[10] = '{"i_aw_only", 1,0,1,0, 1,0,0,1,0, 32'd16};
        vecs[11] = '{"d_w_only",  0,1,0,1, 0,1,0,1,0, 32'd33};

        rst_n = 1'b1;
        idleInputs();
        imem_araddr = '0; dmem_araddr = '0; dmem_awaddr = '0;
        dmem_wdata = '0; dmem_wstrb = '0;
        imem_rready = 1'b1;
        dmem_rready = 1'b1;
        #1 rst_n = 1'b0;

        // Reset holds every output low even with a request pending.
        repeat (2) @(negedge clk);
        imem_araddr = 32'h10;
        imem_arvalid = 1'b1;
        #2;
        checkOutput("rst_imem_arready", {31'd0, imem_arready}, 32'd0);
        checkOutput("rst_mem_en", {31'd0, mem_en}, 32'd0);
        checkOutput("rst_imem_rdata", imem_rdata, 32'd0);
        imem_arvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            checkOutput("rel_mem_en", {31'd0, mem_en}, 32'd0);
            checkOutput("rel_rvalid", {30'd0, imem_rvalid, dmem_rvalid}, 32'd0);
            checkOutput("rel_ready", {28'd0, imem_arready, dmem_arready, dmem_awready, dmem_wready}, 32'd0);
            @(negedge clk);
        end

        $display("[TB] single instruction read");
        imem_araddr = 32'h0000_0010;
        imem_arvalid = 1'b1;
        #2;
        checkOutput("ird_arready", {31'd0, imem_arready}, 32'd1);
        checkOutput("ird_mem_en_we", {30'd0, mem_en, mem_we}, 32'd2);
        checkOutput("ird_mem_addr", {22'd0, mem_addr}, 32'd4);
        @(negedge clk);
        imem_arvalid = 1'b0;
        #2;
        checkOutput("ird_rvalid", {31'd0, imem_rvalid}, 32'd1);
        checkOutput("ird_rdata", imem_rdata, 32'hDEAD_BEEF);
        @(negedge clk);

        $display("[TB] write then same-address read");
        dmem_awaddr = 32'h20; dmem_wdata = 32'h1234_5678; dmem_wstrb = 4'hF;
        dmem_awvalid = 1'b1; dmem_wvalid = 1'b1;
        dmem_araddr = 32'h20; dmem_arvalid = 1'b1;
        #2;
        checkOutput("wr_aw_w_ready", {30'd0, dmem_awready, dmem_wready}, 32'd3);
        checkOutput("wr_dmem_arready", {31'd0, dmem_arready}, 32'd0);
        checkOutput("wr_mem_we", {31'd0, mem_we}, 32'd1);
        checkOutput("wr_mem_addr", {22'd0, mem_addr}, 32'd8);
        checkOutput("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        checkOutput("wr_mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
        @(negedge clk);
        dmem_awvalid = 1'b0; dmem_wvalid = 1'b0;
        #2;
        checkOutput("rd_after_wr_arready", {31'd0, dmem_arready}, 32'd1);
        checkOutput("rd_after_wr_we_strb", {27'd0, mem_we, mem_wstrb}, 32'd0);
        @(negedge clk);
        dmem_arvalid = 1'b0;
        #2;
        checkOutput("rd_after_wr_rvalid", {31'd0, dmem_rvalid}, 32'd1);
        checkOutput("rd_after_wr_rdata", dmem_rdata, 32'h1234_5678);
        @(negedge clk);

        $display("[TB] grant priority table");
        for (int k = 0; k < 12; k++) begin
            applyStimulus(vecs[k], k);
            #2;
            checkOutput({vecs[k].name, "_imem_arready"}, {31'd0, imem_arready}, {31'd0, vecs[k].exp_i});
            checkOutput({vecs[k].name, "_dmem_arready"}, {31'd0, dmem_arready}, {31'd0, vecs[k].exp_d});
            checkOutput({vecs[k].name, "_aw_w_ready"}, {30'd0, dmem_awready, dmem_wready},
                        {30'd0, vecs[k].exp_w, vecs[k].exp_w});
            checkOutput({vecs[k].name, "_mem_en_we"}, {30'd0, mem_en, mem_we},
                        {30'd0, vecs[k].exp_en, vecs[k].exp_we});
            if (vecs[k].exp_en) checkOutput({vecs[k].name, "_mem_addr"}, {22'd0, mem_addr}, vecs[k].exp_addr);
            @(negedge clk);
            idleInputs();
            @(negedge clk);
        end

        $display("[TB] instruction starvation");
        dmem_araddr = 32'h84; dmem_arvalid = 1'b1;
        imem_araddr = 32'h40; imem_arvalid = 1'b1;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 10) begin
            #2;
            if (imem_arready) begin
                got = 1'b1;
                checkOutput("starve_dmem_denied", {31'd0, dmem_arready}, 32'd0);
            end else begin
                cnt++;
                @(negedge clk);
            end
        end
        checkOutput("starve_denied_cycles", cnt, MAX_STARVE);
        @(negedge clk);
        idleInputs();
        repeat (2) @(negedge clk);

        $display("[TB] data read backpressure");
        dmem_araddr = 32'h30; dmem_arvalid = 1'b1;
        #2;
        checkOutput("bp_first_arready", {31'd0, dmem_arready}, 32'd1);
        @(negedge clk);
        dmem_rready = 1'b0;
        dmem_araddr = 32'h84;
        imem_araddr = 32'h40; imem_arvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            checkOutput("bp_rvalid", {31'd0, dmem_rvalid}, 32'd1);
            checkOutput("bp_rdata", dmem_rdata, 32'hCAFE_F00D);
            checkOutput("bp_arready", {31'd0, dmem_arready}, 32'd0);
            @(negedge clk);
        end
        dmem_rready = 1'b1;
        #2;
        checkOutput("bp_release_rdata", dmem_rdata, 32'hCAFE_F00D);
        checkOutput("bp_release_arready", {31'd0, dmem_arready}, 32'd1);
        @(negedge clk);
        idleInputs();
        repeat (2) @(negedge clk);

        $display("[TB] reset during read response");
        imem_araddr = 32'h10; imem_arvalid = 1'b1;
        #2;
        checkOutput("rstmid_arready", {31'd0, imem_arready}, 32'd1);
        @(negedge clk);
        imem_arvalid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstmid_rvalid_now", {31'd0, imem_rvalid}, 32'd0);
        checkOutput("rstmid_rdata_now", imem_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            checkOutput("rstmid_rvalid_after", {30'd0, imem_rvalid, dmem_rvalid}, 32'd0);
            @(negedge clk);
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", iq.size() + dq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
